// File: rtl/mem_stage_lsu_if.sv
// Bus bundle for the MEM stage: EX payload in, data-SRAM read response in,
// WB payload, ID forwarding bus and status flags out.
// With MEM_ALIGN_CHK_EN defined the bundle also carries misalign_o.
interface mem_stage_lsu_if #(
  parameter int PC_W  = 32,
  parameter int RF_AW = 5
);
  // hazard-unit hold
  logic               stall_i;

  // EX -> MEM payload
  logic               ex_valid_i;
  logic [PC_W-1:0]    ex_pc_i;
  logic               ex_ld_i;
  logic [2:0]         ex_ld_type_i;
  logic               ex_rf_we_i;
  logic [RF_AW-1:0]   ex_rf_waddr_i;
  logic [31:0]        ex_result_i;

  // data-SRAM read response
  logic               dmem_rvalid_i;
  logic [31:0]        dmem_rdata_i;

  // stage outputs
  logic               mem_stall_o;
  logic               wb_valid_o;
  logic [PC_W-1:0]    wb_pc_o;
  logic               wb_rf_we_o;
  logic [RF_AW-1:0]   wb_rf_waddr_o;
  logic [31:0]        wb_rf_wdata_o;
  logic [RF_AW+33:0]  fwd_o;
  logic               err_o;
`ifdef MEM_ALIGN_CHK_EN
  logic               misalign_o;
`endif

  // The MEM stage itself
  modport slave (
    input  stall_i,
    input  ex_valid_i, ex_pc_i, ex_ld_i, ex_ld_type_i,
    input  ex_rf_we_i, ex_rf_waddr_i, ex_result_i,
    input  dmem_rvalid_i, dmem_rdata_i,
    output mem_stall_o, wb_valid_o, wb_pc_o, wb_rf_we_o,
    output wb_rf_waddr_o, wb_rf_wdata_o, fwd_o, err_o
`ifdef MEM_ALIGN_CHK_EN
    , output misalign_o
`endif
  );

  // The surrounding pipeline / memory model
  modport master (
    output stall_i,
    output ex_valid_i, ex_pc_i, ex_ld_i, ex_ld_type_i,
    output ex_rf_we_i, ex_rf_waddr_i, ex_result_i,
    output dmem_rvalid_i, dmem_rdata_i,
    input  mem_stall_o, wb_valid_o, wb_pc_o, wb_rf_we_o,
    input  wb_rf_waddr_o, wb_rf_wdata_o, fwd_o, err_o
`ifdef MEM_ALIGN_CHK_EN
    , input misalign_o
`endif
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with load completion handling.
// Registers the EX payload, waits for a variable-latency data-SRAM read
// response, extracts byte/half/word load data with sign or zero extension,
// and drives the WB payload plus an ID forwarding bus with a pending flag.
// Optional feature: define MEM_ALIGN_CHK_EN to flag misaligned LH/LHU/LW
// loads on misalign_o and suppress their register write.
module mem_stage_lsu #(
  parameter int PC_W    = 32,
  parameter int RF_AW   = 5,
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  mem_stage_lsu_if.slave bus
);

  // Stage states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  // Load type encodings; unlisted codes behave as LW
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  // Timeout counter only needs to reach TIMEOUT-1
  localparam int             CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit             TO_EN    = (TIMEOUT != 0);

  // Payload register
  logic               valid_q,   valid_d;
  logic [PC_W-1:0]    pc_q,      pc_d;
  logic               ld_q,      ld_d;
  logic [2:0]         ld_type_q, ld_type_d;
  logic               rf_we_q,   rf_we_d;
  logic [RF_AW-1:0]   waddr_q,   waddr_d;
  logic [31:0]        result_q,  result_d;

  // Load completion tracking
  logic [1:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [31:0]        ld_buf_q,  ld_buf_d;
  logic               err_q,     err_d;

  logic               advance;
  logic [7:0]         ldByte;
  logic [15:0]        ldHalf;
  logic [31:0]        ldData;
  logic [31:0]        wdata;
  logic               wbValid;
  logic               ldNoFwd;
  logic               pending;
  logic               weAllowed;
  logic               fwdWe;

  // The stage only accepts new work when not held and not waiting on memory
  assign advance = !bus.stall_i && (state_q != ST_WAIT);

  // Next-state logic: payload capture, load wait / timeout, sticky error
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    ld_d      = ld_q;
    ld_type_d = ld_type_q;
    rf_we_d   = rf_we_q;
    waddr_d   = waddr_q;
    result_d  = result_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_buf_d  = ld_buf_q;
    err_d     = err_q;

    if (state_q == ST_WAIT) begin
      if (bus.dmem_rvalid_i) begin
        state_d  = ST_READY;
        ld_buf_d = bus.dmem_rdata_i;
        cnt_d    = '0;
      end else if (TO_EN && (cnt_q == CNT_LAST)) begin
        state_d  = ST_READY;
        ld_buf_d = '0;
        cnt_d    = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (advance) begin
      valid_d   = bus.ex_valid_i;
      pc_d      = bus.ex_pc_i;
      ld_d      = bus.ex_valid_i & bus.ex_ld_i;
      ld_type_d = bus.ex_ld_type_i;
      rf_we_d   = bus.ex_rf_we_i;
      waddr_d   = bus.ex_rf_waddr_i;
      result_d  = bus.ex_result_i;
      cnt_d     = '0;
      state_d   = (bus.ex_valid_i & bus.ex_ld_i) ? ST_WAIT : ST_IDLE;
    end
  end

  // State registers with synchronous reset; reset also abandons any outstanding load
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      ld_q      <= 1'b0;
      ld_type_q <= '0;
      rf_we_q   <= 1'b0;
      waddr_q   <= '0;
      result_q  <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ld_buf_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      ld_q      <= ld_d;
      ld_type_q <= ld_type_d;
      rf_we_q   <= rf_we_d;
      waddr_q   <= waddr_d;
      result_q  <= result_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_buf_q  <= ld_buf_d;
      err_q     <= err_d;
    end
  end

  // Lane selection and sign/zero extension of the buffered read word
  always_comb begin
    ldByte = ld_buf_q[7:0];
    case (result_q[1:0])
      2'd0: ldByte = ld_buf_q[7:0];
      2'd1: ldByte = ld_buf_q[15:8];
      2'd2: ldByte = ld_buf_q[23:16];
      2'd3: ldByte = ld_buf_q[31:24];
      default: ldByte = ld_buf_q[7:0];
    endcase
    ldHalf = result_q[1] ? ld_buf_q[31:16] : ld_buf_q[15:0];
    case (ld_type_q)
      LT_LB:   ldData = {{24{ldByte[7]}}, ldByte};
      LT_LBU:  ldData = {24'd0, ldByte};
      LT_LH:   ldData = {{16{ldHalf[15]}}, ldHalf};
      LT_LHU:  ldData = {16'd0, ldHalf};
      default: ldData = ld_buf_q;
    endcase
  end

  assign wdata   = ld_q ? ldData : result_q;
  assign wbValid = valid_q && (state_q != ST_WAIT);

  // A load to x0 must never look like a forwarding source, pending or not
  assign ldNoFwd = ld_q && (waddr_q == '0);
  assign pending = (state_q == ST_WAIT) && rf_we_q && !ldNoFwd;

`ifdef MEM_ALIGN_CHK_EN
  logic isHalf;
  logic isWord;
  logic misalign;
  assign isHalf   = (ld_type_q == LT_LH) || (ld_type_q == LT_LHU);
  assign isWord   = !isHalf && (ld_type_q != LT_LB) && (ld_type_q != LT_LBU);
  assign misalign = valid_q && ld_q &&
                    ((isHalf && result_q[0]) || (isWord && (result_q[1:0] != 2'b00)));
  assign bus.misalign_o = misalign;
  // A misaligned load completes but must not write back or forward
  assign weAllowed = rf_we_q && !misalign;
`else
  assign weAllowed = rf_we_q;
`endif

  assign fwdWe = valid_q && weAllowed && !pending && !ldNoFwd;

  assign bus.mem_stall_o   = (state_q == ST_WAIT);
  assign bus.wb_valid_o    = wbValid;
  assign bus.wb_pc_o       = pc_q;
  assign bus.wb_rf_we_o    = wbValid && weAllowed;
  assign bus.wb_rf_waddr_o = waddr_q;
  assign bus.wb_rf_wdata_o = wdata;
  assign bus.fwd_o         = {pending, fwdWe, waddr_q, wdata};
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed vectors, expected WB records pushed
// into a queue at issue time and checked by an independent monitor.
module tb_mem_stage_lsu;

  localparam int PC_W  = 32;
  localparam int RF_AW = 5;
  localparam int FW    = RF_AW + 34;

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LB  = 3'b001;
  localparam logic [2:0] LBU = 3'b010;
  localparam logic [2:0] LH  = 3'b011;
  localparam logic [2:0] LHU = 3'b100;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        fwdWe;
  } expT;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  expT  expQ[$];

  mem_stage_lsu_if #(.PC_W(PC_W), .RF_AW(RF_AW)) bus ();

  mem_stage_lsu #(.PC_W(PC_W), .RF_AW(RF_AW), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: whenever the stage hands a valid WB payload onward, compare it to the queue head
  always @(negedge clk) begin : monitor
    expT e;
    if (!rst && bus.wb_valid_o && !bus.stall_i) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_wb: got pc 0x%0h with no expected entry", bus.wb_pc_o);
      end else begin
        e = expQ.pop_front();
        checkOutput("wb_pc",      bus.wb_pc_o, e.pc);
        checkOutput("wb_rf_we",   bus.wb_rf_we_o, e.we);
        checkOutput("wb_waddr",   bus.wb_rf_waddr_o, e.waddr);
        checkOutput("wb_wdata",   bus.wb_rf_wdata_o, e.wdata);
        checkOutput("fwd_pending", bus.fwd_o[FW-1], 1'b0);
        checkOutput("fwd_we",     bus.fwd_o[FW-2], e.fwdWe);
        checkOutput("fwd_wdata",  bus.fwd_o[31:0], e.wdata);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    bus.dmem_rvalid_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic ld,
                               input logic [2:0] t, input logic we, input logic [4:0] wa,
                               input logic [31:0] res);
    bus.ex_valid_i    = v;
    bus.ex_pc_i       = pc;
    bus.ex_ld_i       = ld;
    bus.ex_ld_type_i  = t;
    bus.ex_rf_we_i    = we;
    bus.ex_rf_waddr_i = wa;
    bus.ex_result_i   = res;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, LW, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic respond(input logic [31:0] data);
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = data;
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic fwdWe);
    expT e;
    e.pc = pc; e.we = we; e.waddr = wa; e.wdata = wd; e.fwdWe = fwdWe;
    expQ.push_back(e);
  endtask

  // Issue a load, wait `lat` WAIT cycles and deliver the response on the last one
  task automatic doLoad(input logic [31:0] pc, input logic [2:0] t, input logic [4:0] wa,
                        input logic [31:0] addr, input logic [31:0] rdata, input int lat,
                        input logic [31:0] expData);
    applyStimulus(1'b1, pc, 1'b1, t, 1'b1, wa, addr);
    pushExp(pc, 1'b1, wa, expData, 1'b1);
    cycle();
    idle();
    repeat (lat - 1) cycle();
    respond(rdata);
    cycle();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i = 32'h0;
    idle();
    cycle();
    cycle();
    checkOutput("reset wb_valid",  bus.wb_valid_o, 1'b0);
    checkOutput("reset mem_stall", bus.mem_stall_o, 1'b0);
    checkOutput("reset fwd",       bus.fwd_o, '0);
    checkOutput("reset err",       bus.err_o, 1'b0);
    checkOutput("reset wdata",     bus.wb_rf_wdata_o, 32'h0);
    checkOutput("reset pc",        bus.wb_pc_o, 32'h0);
    rst = 1'b0;

    // ALU result passes straight through
    applyStimulus(1'b1, 32'h100, 1'b0, LW, 1'b1, 5'd5, 32'h1234);
    pushExp(32'h100, 1'b1, 5'd5, 32'h1234, 1'b1);
    cycle();
    checkOutput("alu mem_stall", bus.mem_stall_o, 1'b0);
    checkOutput("alu wb_valid",  bus.wb_valid_o, 1'b1);
    checkOutput("alu fwd_we",    bus.fwd_o[FW-2], 1'b1);
    idle();
    cycle();
    checkOutput("bubble wb_valid", bus.wb_valid_o, 1'b0);

    // Stray response while idle is ignored
    respond(32'hFFFF_FFFF);
    cycle();
    checkOutput("stray mem_stall", bus.mem_stall_o, 1'b0);
    checkOutput("stray wb_valid",  bus.wb_valid_o, 1'b0);

    // LB from lane 3, response three cycles later
    applyStimulus(1'b1, 32'h104, 1'b1, LB, 1'b1, 5'd6, 32'h1003);
    pushExp(32'h104, 1'b1, 5'd6, 32'hFFFF_FF80, 1'b1);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      checkOutput("lb mem_stall", bus.mem_stall_o, 1'b1);
      if (i == 0) checkOutput("lb pending", bus.fwd_o[FW-1], 1'b1);
      if (i == 2) respond(32'h80FF_0000);
      cycle();
    end
    checkOutput("lb stall_done", bus.mem_stall_o, 1'b0);
    checkOutput("lb pending_clr", bus.fwd_o[FW-1], 1'b0);

    // Back-to-back halfword/byte/word loads
    doLoad(32'h108, LHU,    5'd7,  32'h2002, 32'h8001_1234, 1, 32'h0000_8001);
    doLoad(32'h10C, LH,     5'd8,  32'h2002, 32'h8001_1234, 2, 32'hFFFF_8001);
    doLoad(32'h110, LBU,    5'd9,  32'h3001, 32'h1234_A5C3, 1, 32'h0000_00A5);
    doLoad(32'h114, 3'b111, 5'd10, 32'h3003, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
    doLoad(32'h118, LH,     5'd11, 32'h3000, 32'h0000_F00F, 1, 32'hFFFF_F00F);
    // Response on the very last WAIT cycle still wins over the timeout
    doLoad(32'h11C, LW,     5'd12, 32'h3004, 32'h5555_AAAA, 4, 32'h5555_AAAA);
    checkOutput("late_rvalid err", bus.err_o, 1'b0);

    // Load to x0: waits, but never pending or forwarding
    applyStimulus(1'b1, 32'h120, 1'b1, LW, 1'b1, 5'd0, 32'h4000);
    pushExp(32'h120, 1'b1, 5'd0, 32'h1111_2222, 1'b0);
    cycle();
    idle();
    checkOutput("x0 mem_stall", bus.mem_stall_o, 1'b1);
    checkOutput("x0 pending",   bus.fwd_o[FW-1], 1'b0);
    respond(32'h1111_2222);
    cycle();

    // Load without register write: no pending, no forward
    applyStimulus(1'b1, 32'h124, 1'b1, LW, 1'b0, 5'd13, 32'h4004);
    pushExp(32'h124, 1'b0, 5'd13, 32'h3333_4444, 1'b0);
    cycle();
    idle();
    checkOutput("nowe pending", bus.fwd_o[FW-1], 1'b0);
    respond(32'h3333_4444);
    cycle();

    // Hold READY for two cycles while a new instruction waits in EX
    applyStimulus(1'b1, 32'h130, 1'b1, LB, 1'b1, 5'd14, 32'h5000);
    pushExp(32'h130, 1'b1, 5'd14, 32'h0000_007F, 1'b1);
    cycle();
    idle();
    respond(32'h0000_007F);
    cycle();
    bus.stall_i = 1'b1;
    applyStimulus(1'b1, 32'h134, 1'b0, LW, 1'b1, 5'd15, 32'h0000_BEEF);
    pushExp(32'h134, 1'b1, 5'd15, 32'h0000_BEEF, 1'b1);
    repeat (2) begin
      cycle();
      checkOutput("hold wb_valid", bus.wb_valid_o, 1'b1);
      checkOutput("hold wdata",    bus.wb_rf_wdata_o, 32'h0000_007F);
      checkOutput("hold pc",       bus.wb_pc_o, 32'h130);
    end
    bus.stall_i = 1'b0;
    cycle();
    idle();
    cycle();

    // No response: forced completion after four WAIT cycles, error is sticky
    applyStimulus(1'b1, 32'h140, 1'b1, LW, 1'b1, 5'd16, 32'h6000);
    pushExp(32'h140, 1'b1, 5'd16, 32'h0, 1'b1);
    cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      checkOutput("timeout mem_stall", bus.mem_stall_o, 1'b1);
      cycle();
    end
    checkOutput("timeout stall_done", bus.mem_stall_o, 1'b0);
    checkOutput("timeout err",        bus.err_o, 1'b1);
    respond(32'hFFFF_FFFF);
    repeat (3) cycle();
    checkOutput("timeout err_sticky", bus.err_o, 1'b1);
    checkOutput("timeout late_rvalid", bus.mem_stall_o, 1'b0);

    // Reset while waiting; the late response must be dropped
    applyStimulus(1'b1, 32'h150, 1'b1, LB, 1'b1, 5'd17, 32'h7000);
    cycle();
    idle();
    checkOutput("rstwait mem_stall", bus.mem_stall_o, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkOutput("rstwait stall",    bus.mem_stall_o, 1'b0);
    checkOutput("rstwait wb_valid", bus.wb_valid_o, 1'b0);
    checkOutput("rstwait err",      bus.err_o, 1'b0);
    checkOutput("rstwait fwd",      bus.fwd_o, '0);
    checkOutput("rstwait wdata",    bus.wb_rf_wdata_o, 32'h0);
    checkOutput("rstwait pc",       bus.wb_pc_o, 32'h0);
    respond(32'h1234_5678);
    cycle();
    checkOutput("rstwait rvalid_ignored", bus.mem_stall_o, 1'b0);
    checkOutput("rstwait wb_after",       bus.wb_valid_o, 1'b0);
    checkOutput("rstwait fwd_after",      bus.fwd_o, '0);

    // Normal operation resumes after reset
    applyStimulus(1'b1, 32'h160, 1'b0, LW, 1'b1, 5'd18, 32'h0000_CAFE);
    pushExp(32'h160, 1'b1, 5'd18, 32'h0000_CAFE, 1'b1);
    cycle();
    idle();
    repeat (3) cycle();

    checkOutput("queue_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
